// File: rtl/dp_pkg.sv
// Shared definitions for the parametrised datapath core: instruction
// classes, field positions, register file geometry and a field decoder.
package dp_pkg;

  // Instruction class held in the top two bits of every word
  typedef enum logic [1:0] {
    CLS_ALU_R = 2'b00,
    CLS_BRZ   = 2'b01,
    CLS_ALU_I = 2'b10,
    CLS_HALT  = 2'b11
  } iclass_e;

  // Core run state; HALT is only left through reset
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam int NUM_REGS = 4;
  localparam int REG_AW   = 2;

  localparam int INSTR_W  = 16;
  localparam int CLS_HI   = 15;
  localparam int CLS_LO   = 14;
  localparam int RSV_HI   = 13;
  localparam int RSV_LO   = 11;
  localparam int OP_BIT   = 10;
  localparam int RD_HI    = 9;
  localparam int RD_LO    = 8;
  localparam int RS_HI    = 7;
  localparam int RS_LO    = 6;
  localparam int RT_HI    = 5;
  localparam int RT_LO    = 4;
  localparam int IMM_HI   = 5;
  localparam int IMM_LO   = 0;
  localparam int OFF_HI   = 9;
  localparam int OFF_LO   = 0;
  localparam int IMM_W    = IMM_HI - IMM_LO + 1;
  localparam int OFF_W    = OFF_HI - OFF_LO + 1;

  // All fields of a word; which ones matter depends on the class
  typedef struct packed {
    iclass_e           cls;
    logic [2:0]        rsv;
    logic              op;   // 0 = add, 1 = sub
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [IMM_W-1:0]  imm;
    logic [OFF_W-1:0]  off;
  } decoded_t;

  // Split a raw instruction word into its named fields
  function automatic decoded_t decode(input logic [INSTR_W-1:0] w);
    decoded_t d;
    d.cls = iclass_e'(w[CLS_HI:CLS_LO]);
    d.rsv = w[RSV_HI:RSV_LO];
    d.op  = w[OP_BIT];
    d.rd  = w[RD_HI:RD_LO];
    d.rs  = w[RS_HI:RS_LO];
    d.rt  = w[RT_HI:RT_LO];
    d.imm = w[IMM_HI:IMM_LO];
    d.off = w[OFF_HI:OFF_LO];
    return d;
  endfunction

endpackage

// File: rtl/dp_regfile.sv
// Four-entry general register file: two combinational read ports and one
// synchronous write port. Reads return the pre-edge contents, so an
// instruction may name its destination as a source.
import dp_pkg::*;

module dp_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              we,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs_reg [NUM_REGS];

  // Asynchronous clear of every register, single write on the rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (we) begin
      regs_reg[wr_addr] <= wr_data;
    end
  end

  assign rs_data = regs_reg[rs_addr];
  assign rt_data = regs_reg[rt_addr];

endmodule

// File: rtl/param_datapath.sv
// Single-issue datapath core: decodes the word at PC, runs the ALU or
// branch, updates flags and PC, and reports every register write on the
// writeback trace. One instruction per cycle whenever instr_valid is high.
import dp_pkg::*;

module param_datapath #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              _CLK,
  input  logic              RESET,
  input  logic [15:0]       instruction,
  input  logic              instr_valid,
  output logic [PC_W-1:0]   PC,
  output logic              halted,
  output logic              illegal,
  output logic              wb_en,
  output logic [1:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_z,
  output logic              flag_c
);

  // Branch arithmetic is done wide enough for both the PC and the offset,
  // then truncated so targets wrap exactly like sequential fetch.
  localparam int BR_W = (PC_W > OFF_W) ? PC_W : OFF_W;

  state_e            state_reg;
  logic [PC_W-1:0]   pc_reg;
  logic              halted_reg;
  logic              illegal_reg;
  logic              wb_en_reg;
  logic [1:0]        wb_addr_reg;
  logic [DATA_W-1:0] wb_data_reg;
  logic              z_reg;
  logic              c_reg;

  decoded_t          dec;
  logic              exec_ok;
  logic              instr_legal;
  logic              is_alu;
  logic              alu_we;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] operand_b;
  logic [DATA_W:0]   alu_full;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   br_target;

  assign dec         = decode(instruction);
  assign exec_ok     = (state_reg == ST_RUN) && instr_valid;
  assign instr_legal = (dec.rsv == 3'b000);
  assign is_alu      = (dec.cls == CLS_ALU_R) || (dec.cls == CLS_ALU_I);
  // Register writes happen in the same edge as the flag/trace update
  assign alu_we      = exec_ok && instr_legal && is_alu;

  dp_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk     (_CLK),
    .rst_n   (RESET),
    .rs_addr (dec.rs),
    .rt_addr (dec.rt),
    .rs_data (rs_val),
    .rt_data (rt_val),
    .we      (alu_we),
    .wr_addr (dec.rd),
    .wr_data (alu_result)
  );

  // Second ALU operand: register rt, or the zero-extended 6-bit immediate
  always_comb begin
    operand_b = rt_val;
    if (dec.cls == CLS_ALU_I) begin
      operand_b = DATA_W'(dec.imm);
    end
  end

  // One extra bit captures carry-out on add and borrow (rs < operand) on sub
  always_comb begin
    alu_full = {1'b0, rs_val} + {1'b0, operand_b};
    if (dec.op) begin
      alu_full = {1'b0, rs_val} - {1'b0, operand_b};
    end
  end

  assign alu_result = alu_full[DATA_W-1:0];
  assign alu_carry  = alu_full[DATA_W];

  assign pc_inc    = pc_reg + PC_W'(1);
  assign br_target = PC_W'(BR_W'(pc_inc) + BR_W'($signed(dec.off)));

  // Run/halt FSM with all architectural outputs registered
  always_ff @(posedge _CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg   <= ST_RUN;
      pc_reg      <= '0;
      halted_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      wb_en_reg   <= 1'b0;
      wb_addr_reg <= '0;
      wb_data_reg <= '0;
      z_reg       <= 1'b0;
      c_reg       <= 1'b0;
    end else begin
      wb_en_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      if (exec_ok) begin
        if (!instr_legal) begin
          illegal_reg <= 1'b1;
          pc_reg      <= pc_inc;
        end else begin
          case (dec.cls)
            CLS_ALU_R, CLS_ALU_I: begin
              wb_en_reg   <= 1'b1;
              wb_addr_reg <= dec.rd;
              wb_data_reg <= alu_result;
              z_reg       <= (alu_result == '0);
              c_reg       <= alu_carry;
              pc_reg      <= pc_inc;
            end
            CLS_BRZ: begin
              pc_reg <= z_reg ? br_target : pc_inc;
            end
            default: begin
              state_reg  <= ST_HALT;
              halted_reg <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign PC      = pc_reg;
  assign halted  = halted_reg;
  assign illegal = illegal_reg;
  assign wb_en   = wb_en_reg;
  assign wb_addr = wb_addr_reg;
  assign wb_data = wb_data_reg;
  assign flag_z  = z_reg;
  assign flag_c  = c_reg;

endmodule
